ram512: RTL and testbench

512-word × 16-bit random-access memory with one combinational read port and one synchronous write port sharing a single address. It is the third level of the RAM hierarchy, built from eight 64-word banks. It sits under the larger RAM blocks and in the data-memory path of the CPU. Reads are asynchronous; writes and reset take effect on the rising clock edge.

---
 rtl/ram512_if.sv | 10 +
 rtl/ram512.sv | 50 +++++
 tb/tb_ram512.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ram512_if.sv
// Single-port memory bus for ram512: shared address, write data/enable, combinational read data.
interface ram512_if;
  logic [15:0] data_in;
  logic        load;
  logic [8:0]  address;
  logic [15:0] data_out;

  modport master (output data_in, output load, output address, input data_out);
  modport slave  (input data_in, input load, input address, output data_out);
endinterface

// File: rtl/ram512.sv
// 512x16 RAM built from eight 64-word banks; async read, sync write, sync clear.
// Optional macro RAM512_WRITE_THROUGH_EN forwards write data to the read port while load is high.
module ram512 (
  input  logic    clk_i,
  input  logic    reset_i,
  ram512_if.slave bus
);
  localparam int NBANKS     = 8;
  localparam int BANK_WORDS = 64;

  logic [2:0]        bank_sel;
  logic [5:0]        word_sel;
  logic [15:0]       word_d;
  logic [NBANKS-1:0] bank_we;
  logic [15:0]       bank_rd [NBANKS];
  logic [15:0]       mem_rd;

  assign bank_sel = bus.address[8:6];
  assign word_sel = bus.address[5:0];
  assign word_d   = bus.data_in;

  // Only the addressed bank sees the write enable.
  always_comb begin
    bank_we = '0;
    if (bus.load) bank_we[bank_sel] = 1'b1;
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [15:0] mem_q [BANK_WORDS];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int w = 0; w < BANK_WORDS; w++) mem_q[w] <= '0;
      end else if (bank_we[b]) begin
        mem_q[word_sel] <= word_d;
      end
    end

    assign bank_rd[b] = mem_q[word_sel];
  end

  assign mem_rd = bank_rd[bank_sel];

`ifdef RAM512_WRITE_THROUGH_EN
  assign bus.data_out = bus.load ? bus.data_in : mem_rd;
`else
  assign bus.data_out = mem_rd;
`endif

endmodule

// File: tb/tb_ram512.sv
// Directed bench for ram512: reference memory model plus an expected-value queue checked on each read.
module tb_ram512;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [15:0] model [512];
  logic [15:0] exp_q [$];
  string       tag_q [$];

  ram512_if bus ();

  ram512 dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    logic [15:0] exp;
    string       tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    total++;
    assert (bus.data_out === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, bus.data_out, exp);
    end
  endtask

  task automatic expect_val(input logic [15:0] v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = 16'h0000;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    bus.address = a;
    bus.data_in = d;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    model[a] = d;
  endtask

  task automatic do_read(input logic [8:0] a, input string tag);
    bus.load    = 1'b0;
    bus.address = a;
    expect_val(model[a], tag);
  endtask

  logic [8:0]  wr_addr [11];
  logic [15:0] wr_data [11];
  logic [8:0]  ra;
  logic [15:0] rd;

  initial begin
    total = 0;
    bad   = 0;
    wr_addr = '{9'd1, 9'd8, 9'd10, 9'd25, 9'd37, 9'd48, 9'd63, 9'd163, 9'd263, 9'd363, 9'd511};
    wr_data = '{16'h0001, 16'h2008, 16'h300a, 16'h4025, 16'h5037, 16'h6048,
                16'h7063, 16'h7163, 16'h7263, 16'h7363, 16'h7511};
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.data_in = 16'h0000;
    bus.address = 9'd0;

    // reset then sweep
    do_reset();
    do_read(9'd0,   "rst_0");
    do_read(9'd255, "rst_255");
    do_read(9'd511, "rst_511");

    // write/readback across banks
    for (int i = 0; i < 11; i++) do_write(wr_addr[i], wr_data[i]);
    for (int i = 0; i < 11; i++) do_read(wr_addr[i], $sformatf("rdbk_%0d", wr_addr[i]));
    do_read(9'd0, "unwritten_0");
    for (int i = 0; i < 11; i++) begin
      total++;
      assert (model[wr_addr[i]] === wr_data[i])
      else begin
        bad++;
        $error("FAIL model_%0d: observed %h expected %h", wr_addr[i], model[wr_addr[i]], wr_data[i]);
      end
    end

    // no write while load low: three edges with different data on the bus
    bus.load    = 1'b0;
    bus.address = 9'd37;
    bus.data_in = 16'hdead;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      expect_val(16'h5037, $sformatf("noload_e%0d", e));
    end

    // bank isolation
    do_write(9'd63, 16'haaaa);
    do_write(9'd64, 16'h5555);
    do_write(9'd0,  16'h1234);
    do_read(9'd63,  "iso_63");
    do_read(9'd64,  "iso_64");
    do_read(9'd448, "iso_448");
    do_read(9'd0,   "iso_0");
    do_read(9'd65,  "iso_65");

    // address/data changes between edges only land on the edge
    bus.address = 9'd100;
    bus.data_in = 16'h0bad;
    bus.load    = 1'b1;
    #1;
    bus.address = 9'd101;
    bus.data_in = 16'hc0de;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    model[101] = 16'hc0de;
    do_read(9'd100, "late_100");
    do_read(9'd101, "late_101");

    // pseudo-random writes, back-to-back, then readback
    for (int i = 0; i < 24; i++) begin
      ra = 9'($urandom_range(0, 511));
      rd = 16'($urandom);
      do_write(ra, rd);
    end
    for (int i = 0; i < 512; i += 37) do_read(9'(i), $sformatf("sweep_%0d", i));

    // write cycle: read port during load
    bus.address = 9'd200;
    bus.data_in = 16'hbeef;
    bus.load    = 1'b1;
`ifdef RAM512_WRITE_THROUGH_EN
    expect_val(16'hbeef, "wt_bypass");
`else
    expect_val(model[200], "wt_old");
`endif
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    model[200] = 16'hbeef;
    do_read(9'd200, "wt_after");

    // reset priority over load
    reset       = 1'b1;
    bus.load    = 1'b1;
    bus.address = 9'd5;
    bus.data_in = 16'hffff;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.load = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = 16'h0000;
    do_read(9'd5,   "rstpri_5");
    do_read(9'd511, "rstpri_511");
    do_read(9'd37,  "rstpri_37");
    do_read(9'd200, "rstpri_200");

    // normal writes resume after reset
    do_write(9'd300, 16'h1357);
    do_read(9'd300, "resume_300");
    do_read(9'd301, "resume_301");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
